// File: rtl/bus_master_if.sv
// Master-side request/grant front end for the shared arbitrated bus.
// Takes one burst command at a time, requests the bus, drives the beats and releases.
module bus_master_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_wr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Value the wait counter holds on the edge that completes the MAX_WAIT-th grantless cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat;
  logic [WAIT_W-1:0]   wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign wdata_pop = bus_valid & bus_wr & grant;
  assign bus_wdata = (bus_valid && bus_wr) ? wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req       <= 1'b0;
      bus_valid <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      len_q     <= '0;
      beat      <= '0;
      wait_cnt  <= '0;
    end else begin
      // done/err and rd_valid are single-cycle pulses unless re-armed below.
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q   <= cmd_addr;
            wr_q     <= cmd_wr;
            len_q    <= cmd_len;
            req      <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (grant) begin
            beat      <= '0;
            bus_valid <= 1'b1;
            bus_wr    <= wr_q;
            bus_addr  <= addr_q;
            state     <= XFER;
          end else if (MAX_WAIT != 0) begin
            if (wait_cnt == WAIT_LAST) begin
              req   <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
              state <= REL;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        XFER: begin
          // A beat only completes on an edge where grant is still held.
          if (!grant) begin
            req       <= 1'b0;
            bus_valid <= 1'b0;
            bus_wr    <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= REL;
          end else begin
            if (!bus_wr) begin
              rd_data  <= bus_rdata;
              rd_valid <= 1'b1;
            end
            if (beat == len_q) begin
              req       <= 1'b0;
              bus_valid <= 1'b0;
              bus_wr    <= 1'b0;
              done      <= 1'b1;
              state     <= REL;
            end else begin
              beat     <= beat + 1'b1;
              bus_addr <= bus_addr + 1'b1;
            end
          end
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: grant is a registered copy of req, gated by the bench,
// and expected beats, read data and done/err outcomes are queued with the cycle they must appear in.
module tb_bus_master_if;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic       cmd_wr;
  logic [3:0] cmd_len;
  logic [7:0] wdata;
  logic       wdata_pop;
  logic       req;
  logic       grant;
  logic       bus_valid;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } exp_t;

  exp_t beatQ[$];
  exp_t rdQ[$];
  exp_t doneQ[$];

  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;
  int   popsTotal = 0;
  int   expPops = 0;
  int   reqHigh = 0;
  logic grantEnable = 1'b1;

  bus_master_if #(
    .ADDR_W(8), .DATA_W(8), .LEN_W(4), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .req(req), .grant(grant),
    .bus_valid(bus_valid), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter stand-in: grant is req delayed by one cycle, suppressed while grantEnable is low.
  always @(posedge clk) grant <= reset ? 1'b0 : (req & grantEnable);

  assign wdata     = 8'(32'hC0 + popsTotal);
  assign bus_rdata = bus_addr ^ 8'hA5;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitor: every DUT output event pops and is compared against the head of its queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req) reqHigh++;
        if (bus_valid) begin
          if (beatQ.size() == 0) begin
            checkOutput("unexpectedBeat", 1, 0);
          end else begin
            e = beatQ.pop_front();
            checkOutput("beatCycle", cyc, e.cyc);
            checkOutput("beatAddr", bus_addr, e.a);
            checkOutput("beatWr", bus_wr, e.b);
            if (e.b != 0) checkOutput("beatWdata", bus_wdata, e.c);
          end
          if (wdata_pop) popsTotal++;
        end
        if (rd_valid) begin
          if (rdQ.size() == 0) begin
            checkOutput("unexpectedRead", 1, 0);
          end else begin
            e = rdQ.pop_front();
            checkOutput("rdCycle", cyc, e.cyc);
            checkOutput("rdData", rd_data, e.a);
          end
        end
        if (done) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
          end else begin
            e = doneQ.pop_front();
            checkOutput("doneCycle", cyc, e.cyc);
            checkOutput("doneErr", err, e.a);
            checkOutput("reqLowInRel", req, 0);
            checkOutput("busIdleInRel", bus_valid, 0);
          end
        end
      end
    end
  end

  // Offers a command and returns base such that spec cycle n is seen at negedge with cyc == base+n.
  task automatic applyStimulus(input logic [7:0] addr, input logic wr, input logic [3:0] len,
                               output int base);
    int n = 0;
    @(negedge clk); #1;
    cmd_addr  = addr;
    cmd_wr    = wr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("cmdReady", cmd_ready, 1);
    checkOutput("reqBeforeAccept", req, 0);
    base = cyc;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("reqCycle1", req, 1);
    checkOutput("busyCycle1", cmd_ready, 0);
  endtask

  task automatic expectBurst(input int base, input logic [7:0] addr, input logic wr,
                             input int onBus, input int completed, input int doneAt,
                             input logic errv);
    for (int i = 0; i < onBus; i++)
      beatQ.push_back('{base + 3 + i, int'(8'(addr + i)), int'(wr), int'(8'(32'hC0 + expPops + i))});
    if (!wr)
      for (int i = 0; i < completed; i++)
        rdQ.push_back('{base + 4 + i, int'(8'(addr + i) ^ 8'hA5), 0, 0});
    if (doneAt >= 0) doneQ.push_back('{doneAt, int'(errv), 0, 0});
    if (wr) expPops += completed;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((beatQ.size() + rdQ.size() + doneQ.size()) != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checkOutput("drainTimeout", 1, 0);
      beatQ.delete();
      rdQ.delete();
      doneQ.delete();
    end
    checkOutput("readyInRel", cmd_ready, 0);
    checkOutput("reqInRel", req, 0);
    @(negedge clk); #1;
    checkOutput("readyAfterRel", cmd_ready, 1);
    checkOutput("donePulse", done, 0);
    checkOutput("errPulse", err, 0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int p0;
    int r0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wr    = 1'b0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstReq", req, 0);
    checkOutput("rstBusValid", bus_valid, 0);
    checkOutput("rstBusAddr", bus_addr, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstRdValid", rd_valid, 0);
    checkOutput("rstReady", cmd_ready, 1);
    reset = 1'b0;

    $display("[TB] write 0x10 len 3");
    p0 = popsTotal;
    applyStimulus(8'h10, 1'b1, 4'd3, base);
    expectBurst(base, 8'h10, 1'b1, 4, 4, base + 7, 1'b0);
    waitIdle();
    checkOutput("writePops", popsTotal - p0, 4);

    $display("[TB] read 0xFE len 2 with address wrap");
    applyStimulus(8'hFE, 1'b0, 4'd2, base);
    expectBurst(base, 8'hFE, 1'b0, 3, 3, base + 6, 1'b0);
    waitIdle();

    $display("[TB] single-beat write at 0xFF");
    applyStimulus(8'hFF, 1'b1, 4'd0, base);
    expectBurst(base, 8'hFF, 1'b1, 1, 1, base + 4, 1'b0);
    waitIdle();

    $display("[TB] grant never arrives");
    grantEnable = 1'b0;
    r0 = reqHigh;
    applyStimulus(8'h20, 1'b1, 4'd7, base);
    expectBurst(base, 8'h20, 1'b1, 0, 0, base + 16, 1'b1);
    waitIdle();
    checkOutput("timeoutReqCycles", reqHigh - r0, 15);
    grantEnable = 1'b1;

    $display("[TB] grant lost after two beats of a len-5 write");
    p0 = popsTotal;
    applyStimulus(8'h30, 1'b1, 4'd5, base);
    expectBurst(base, 8'h30, 1'b1, 3, 2, base + 6, 1'b1);
    repeat (3) begin
      @(negedge clk); #1;
    end
    grantEnable = 1'b0;
    waitIdle();
    grantEnable = 1'b1;
    checkOutput("dropPops", popsTotal - p0, 2);

    $display("[TB] reset during a read burst");
    applyStimulus(8'h40, 1'b0, 4'd5, base);
    expectBurst(base, 8'h40, 1'b0, 2, 1, -1, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("midRstReq", req, 0);
    checkOutput("midRstBusValid", bus_valid, 0);
    checkOutput("midRstBusWr", bus_wr, 0);
    checkOutput("midRstBusAddr", bus_addr, 0);
    checkOutput("midRstRdData", rd_data, 0);
    checkOutput("midRstRdValid", rd_valid, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstErr", err, 0);
    checkOutput("midRstReady", cmd_ready, 1);
    reset = 1'b0;
    checkOutput("midRstBeatsDrained", beatQ.size() + rdQ.size() + doneQ.size(), 0);
    repeat (4) @(negedge clk);

    $display("[TB] command after reset");
    p0 = popsTotal;
    applyStimulus(8'h50, 1'b1, 4'd1, base);
    expectBurst(base, 8'h50, 1'b1, 2, 2, base + 5, 1'b0);
    waitIdle();
    checkOutput("postRstPops", popsTotal - p0, 2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
